mem_line_responder: RTL and testbench

Synthesizable memory-side responder for the C2 (cache↔memory) bus. Sits directly downstream of the cache: it accepts whole-line read and write commands, stores lines in an internal array, and answers after a fixed latency. The bus is split into in/out/output-enable pins so the block can be synthesized; the top level builds the tri-state wires.

---
 rtl/mem_line_responder_pkg.sv | 43 ++++
 rtl/mem_line_responder_if.sv | 38 +++
 rtl/mem_line_array.sv | 29 ++
 rtl/mem_line_responder.sv | 206 ++++++++++++++++++++
 tb/tb_mem_line_responder.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_line_responder_pkg.sv
// Shared definitions for the C2 memory-side line responder: bus command
// codes, default geometry, the packed line type and the FSM state encoding.
// Optional feature macro used by this slice: MEM_PROTOCOL_CHECK_EN.
package mem_line_responder_pkg;

  // C2 bus command encoding as it appears on the wire.
  localparam logic [1:0] C2_NOP        = 2'd0;
  localparam logic [1:0] C2_RESPONSE   = 2'd1;
  localparam logic [1:0] C2_READ_LINE  = 2'd2;
  localparam logic [1:0] C2_WRITE_LINE = 2'd3;

  // Default geometry; modules take these as parameter defaults.
  localparam int DEF_ADDR_W     = 14;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_LINE_BYTES = 16;
  localparam int DEF_LATENCY    = 100;

  // Beats per line for the default geometry.
  localparam int BEATS = DEF_LINE_BYTES * 8 / DEF_DATA_W;

  // One whole cache line, byte 0 in the low bits.
  typedef logic [DEF_LINE_BYTES*8-1:0] line_t;

  // Responder FSM states, exported for debug/checker binding.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_BEATS = 2'd1,
    ST_WAIT     = 2'd2,
    ST_RESP     = 2'd3
  } state_t;

  // Kind of the single outstanding command.
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Beats per line for an arbitrary geometry.
  function automatic int beats_of(input int line_bytes, input int data_w);
    return line_bytes * 8 / data_w;
  endfunction

endpackage

// File: rtl/mem_line_responder_if.sv
// C2 bus as seen by the memory responder, split into input, output and
// output-enable pins; the tri-state wires are built above this level.
//
// Bus semantics: there is no valid/ready pair. A command is "valid" in the
// cycle where cmd_i is READ_LINE or WRITE_LINE, and it is taken on that
// posedge only if the responder is idle (only one command is ever
// outstanding). Write data follows as consecutive beats from the command
// cycle on. The responder answers with cmd_o=RESPONSE while cmd_oe=1; read
// data is valid exactly when data_oe=1.
interface mem_line_responder_if
  import mem_line_responder_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [ADDR_W-1:0] addr_i;
  logic [1:0]        cmd_i;
  logic [1:0]        cmd_o;
  logic              cmd_oe;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] data_o;
  logic              data_oe;
  logic              proto_err;

  // Cache side: issues commands and write beats.
  modport master (
    output addr_i, cmd_i, data_i,
    input  cmd_o, cmd_oe, data_o, data_oe, proto_err
  );

  // Memory side: this responder.
  modport slave (
    input  addr_i, cmd_i, data_i,
    output cmd_o, cmd_oe, data_o, data_oe, proto_err
  );

endinterface

// File: rtl/mem_line_array.sv
// Single-port line storage: full-line synchronous write, synchronous read
// with one cycle of latency. Contents start at zero and are not touched by
// reset, so data survives a responder reset.
module mem_line_array
  import mem_line_responder_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_BYTES * 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [LINE_W-1:0] mem [DEPTH] = '{default: '0};

  // Write the whole line when asked; always read the addressed line.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side responder for the C2 bus. Takes whole-line READ_LINE and
// WRITE_LINE commands, keeps lines in mem_line_array and answers a fixed
// LATENCY cycles after the command cycle. All bus outputs are registered.
// Optional feature: MEM_PROTOCOL_CHECK_EN enables the sticky proto_err flag.
module mem_line_responder
  import mem_line_responder_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_line_responder_if.slave  bus,
  output state_t               state_dbg
);

  localparam int LINE_W = LINE_BYTES * 8;
  localparam int NBEATS = beats_of(LINE_BYTES, DATA_W);
  localparam int LAT_W  = $clog2(LATENCY + 1);
  localparam int BEAT_W = $clog2(NBEATS + 1);

  state_t              state_q, state_n;
  op_t                 op_q, op_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [LAT_W-1:0]    lat_q, lat_n;
  logic [BEAT_W-1:0]   beat_q, beat_n;
  logic [LINE_W-1:0]   line_q, line_n;
  logic                wr_pend_q, wr_pend_n;
  logic [1:0]          cmd_o_q, cmd_o_n;
  logic                cmd_oe_q, cmd_oe_n;
  logic [DATA_W-1:0]   data_o_q, data_o_n;
  logic                data_oe_q, data_oe_n;

  logic [LINE_W-1:0]   rd_line;
  logic [LINE_W-1:0]   shift_in;

  // line_q doubles as the write assembler (beats enter at the top and move
  // down, so beat 0 ends in the low bits) and the read serialiser (beats
  // leave from the bottom).
  assign shift_in = (line_q >> DATA_W) | (LINE_W'(bus.data_i) << (LINE_W - DATA_W));

  // Line storage; the write fires the cycle after the last beat, and the
  // read address is stable from the command cycle so the data is ready long
  // before the response starts.
  mem_line_array #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W)
  ) u_array (
    .clk   (clk),
    .we    (wr_pend_q),
    .addr  (addr_q),
    .wdata (line_q),
    .rdata (rd_line)
  );

  // Next-state, counter, line and registered-output computation.
  always_comb begin
    state_n   = state_q;
    op_n      = op_q;
    addr_n    = addr_q;
    lat_n     = lat_q;
    beat_n    = beat_q;
    line_n    = line_q;
    wr_pend_n = 1'b0;
    cmd_o_n   = C2_NOP;
    cmd_oe_n  = 1'b0;
    data_o_n  = '0;
    data_oe_n = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_i == C2_READ_LINE) begin
          addr_n  = bus.addr_i;
          op_n    = OP_READ;
          lat_n   = '0;
          state_n = ST_WAIT;
        end else if (bus.cmd_i == C2_WRITE_LINE) begin
          addr_n = bus.addr_i;
          op_n   = OP_WRITE;
          lat_n  = '0;
          line_n = shift_in;
          beat_n = BEAT_W'(1);
          if (NBEATS == 1) begin
            wr_pend_n = 1'b1;
            state_n   = ST_WAIT;
          end else begin
            state_n = ST_WR_BEATS;
          end
        end
      end

      ST_WR_BEATS: begin
        lat_n  = lat_q + LAT_W'(1);
        line_n = shift_in;
        beat_n = beat_q + BEAT_W'(1);
        if (beat_q == BEAT_W'(NBEATS - 1)) begin
          wr_pend_n = 1'b1;
          state_n   = ST_WAIT;
        end
      end

      ST_WAIT: begin
        lat_n = lat_q + LAT_W'(1);
        // Load the first response cycle so it appears right after the
        // posedge at command cycle + LATENCY.
        if (lat_q == LAT_W'(LATENCY - 1)) begin
          state_n  = ST_RESP;
          cmd_oe_n = 1'b1;
          cmd_o_n  = C2_RESPONSE;
          if (op_q == OP_READ) begin
            data_oe_n = 1'b1;
            data_o_n  = rd_line[DATA_W-1:0];
            line_n    = rd_line >> DATA_W;
            beat_n    = BEAT_W'(1);
          end
        end
      end

      ST_RESP: begin
        if ((op_q == OP_READ) && (beat_q != BEAT_W'(NBEATS))) begin
          cmd_oe_n  = 1'b1;
          cmd_o_n   = C2_RESPONSE;
          data_oe_n = 1'b1;
          data_o_n  = line_q[DATA_W-1:0];
          line_n    = line_q >> DATA_W;
          beat_n    = beat_q + BEAT_W'(1);
        end else begin
          state_n = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops every enable immediately and
  // cancels a pending write, leaving the array untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_READ;
      addr_q    <= '0;
      lat_q     <= '0;
      beat_q    <= '0;
      line_q    <= '0;
      wr_pend_q <= 1'b0;
      cmd_o_q   <= C2_NOP;
      cmd_oe_q  <= 1'b0;
      data_o_q  <= '0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      op_q      <= op_n;
      addr_q    <= addr_n;
      lat_q     <= lat_n;
      beat_q    <= beat_n;
      line_q    <= line_n;
      wr_pend_q <= wr_pend_n;
      cmd_o_q   <= cmd_o_n;
      cmd_oe_q  <= cmd_oe_n;
      data_o_q  <= data_o_n;
      data_oe_q <= data_oe_n;
    end
  end

  assign bus.cmd_o   = cmd_o_q;
  assign bus.cmd_oe  = cmd_oe_q;
  assign bus.data_o  = data_o_q;
  assign bus.data_oe = data_oe_q;
  assign state_dbg   = state_q;

`ifdef MEM_PROTOCOL_CHECK_EN
  logic proto_evt;
  logic proto_err_q;

  // Someone else drives a command while we are busy and not driving, or a
  // RESPONSE appears while we have nothing outstanding.
  assign proto_evt = ((state_q != ST_IDLE) && (bus.cmd_i != C2_NOP) && !cmd_oe_q) ||
                     ((state_q == ST_IDLE) && (bus.cmd_i == C2_RESPONSE));

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proto_err_q <= 1'b0;
    end else if (proto_evt) begin
      proto_err_q <= 1'b1;
    end
  end

  assign bus.proto_err = proto_err_q;

`ifndef SYNTHESIS
  // Report each illegal bus command as it happens.
  always @(posedge clk) begin
    if (!reset && proto_evt) begin
      $error("mem_line_responder: illegal cmd %0d in state %s", bus.cmd_i, state_q.name());
    end
  end
`endif
`else
  assign bus.proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: a default-latency instance and a
// LATENCY=BEATS+1 instance share stimulus through a select; a negedge
// scoreboard checks every RESPONSE cycle against an expected queue.
module tb_mem_line_responder;
  import mem_line_responder_pkg::*;

  localparam int AW   = 14;
  localparam int DW   = 16;
  localparam int LB   = 16;
  localparam int LW   = LB * 8;
  localparam int NB   = LB * 8 / DW;
  localparam int LAT0 = 100;
  localparam int LAT1 = NB + 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus and DUTs ----------------
  logic          sel      = 1'b0;
  logic [1:0]    cmd_drv  = C2_NOP;
  logic [AW-1:0] addr_drv = '0;
  logic [DW-1:0] data_drv = '0;

  mem_line_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  mem_line_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  assign bus0.addr_i = addr_drv;
  assign bus0.data_i = data_drv;
  assign bus0.cmd_i  = sel ? C2_NOP : cmd_drv;
  assign bus1.addr_i = addr_drv;
  assign bus1.data_i = data_drv;
  assign bus1.cmd_i  = sel ? cmd_drv : C2_NOP;

  state_t st0, st1;

  mem_line_responder #(.ADDR_W(AW), .DATA_W(DW), .LINE_BYTES(LB), .LATENCY(LAT0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus0),
    .state_dbg (st0)
  );

  mem_line_responder #(.ADDR_W(AW), .DATA_W(DW), .LINE_BYTES(LB), .LATENCY(LAT1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus1),
    .state_dbg (st1)
  );

  logic          m_cmd_oe, m_data_oe;
  logic [1:0]    m_cmd_o;
  logic [DW-1:0] m_data_o;
  assign m_cmd_oe  = sel ? bus1.cmd_oe  : bus0.cmd_oe;
  assign m_cmd_o   = sel ? bus1.cmd_o   : bus0.cmd_o;
  assign m_data_oe = sel ? bus1.data_oe : bus0.data_oe;
  assign m_data_o  = sel ? bus1.data_o  : bus0.data_o;

  // ---------------- scoreboard ----------------
  int            n_cmp  = 0;
  int            n_fail = 0;
  int            n_resp = 0;
  logic [DW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic          exp_doe_q[$];
  logic [LW-1:0] model_line [int];

  logic [DW-1:0] e_d;
  int            e_c;
  logic          e_o;

  always @(negedge clk) begin
    if (!reset && m_cmd_oe) begin
      n_resp++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: response cmd %0d oe %0b data %h at cycle %0d, required no response",
                 m_cmd_o, m_data_oe, m_data_o, cyc);
      end else begin
        e_d = exp_q.pop_front();
        e_c = exp_cyc_q.pop_front();
        e_o = exp_doe_q.pop_front();
        if (cyc !== e_c || m_cmd_o !== C2_RESPONSE || m_data_oe !== e_o || (e_o && m_data_o !== e_d)) begin
          n_fail++;
          $display("FAIL sb_beat: got cycle %0d cmd %0d data_oe %0b data %h, required cycle %0d cmd %0d data_oe %0b data %h",
                   cyc, m_cmd_o, m_data_oe, m_data_o, e_c, C2_RESPONSE, e_o, e_d);
        end
      end
    end
  end

  // ---------------- driver / model helpers ----------------
  function automatic logic [LW-1:0] make_line(input logic [7:0] seed);
    logic [LW-1:0] l;
    for (int i = 0; i < LB; i++) l[i*8 +: 8] = 8'(i * 17) + seed;
    return l;
  endfunction

  function automatic int key_of(input logic s, input logic [AW-1:0] a);
    return int'(a) + (s ? 65536 : 0);
  endfunction

  function automatic logic [LW-1:0] model_get(input int k);
    if (model_line.exists(k)) return model_line[k];
    return '0;
  endfunction

  task automatic clear_exp();
    exp_q.delete();
    exp_cyc_q.delete();
    exp_doe_q.delete();
  endtask

  task automatic push_read(input logic [LW-1:0] line, input int t0, input int lat);
    for (int k = 0; k < NB; k++) begin
      exp_q.push_back(line[k*DW +: DW]);
      exp_cyc_q.push_back(t0 + lat + k);
      exp_doe_q.push_back(1'b1);
    end
  endtask

  task automatic push_write_resp(input int t0, input int lat);
    exp_q.push_back('0);
    exp_cyc_q.push_back(t0 + lat);
    exp_doe_q.push_back(1'b0);
  endtask

  task automatic issue_read(input logic [AW-1:0] a, output int t0);
    @(negedge clk);
    cmd_drv  = C2_READ_LINE;
    addr_drv = a;
    @(posedge clk);
    #1;
    t0      = cyc;
    cmd_drv = C2_NOP;
  endtask

  // abort_at < NB asserts reset in place of that beat and leaves it asserted.
  task automatic issue_write(input logic [AW-1:0] a, input logic [LW-1:0] line,
                             input int abort_at, output int t0);
    @(negedge clk);
    cmd_drv  = C2_WRITE_LINE;
    addr_drv = a;
    data_drv = line[DW-1:0];
    @(posedge clk);
    #1;
    t0      = cyc;
    cmd_drv = C2_NOP;
    for (int k = 1; k < NB; k++) begin
      if (k == abort_at) begin
        reset = 1'b1;
        break;
      end
      data_drv = line[k*DW +: DW];
      @(posedge clk);
      #1;
    end
    data_drv = '0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus0.cmd_oe !== 1'b0 || bus0.cmd_o !== C2_NOP) begin
      n_fail++;
      $display("FAIL reset_cmd: got oe %0b cmd %0d, required oe 0 cmd 0", bus0.cmd_oe, bus0.cmd_o);
    end
    n_cmp++;
    if (bus0.data_oe !== 1'b0 || bus0.data_o !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got oe %0b data %h, required oe 0 data 0000", bus0.data_oe, bus0.data_o);
    end
    n_cmp++;
    if (bus0.proto_err !== 1'b0 || bus1.proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_proto: got %0b/%0b, required 0/0", bus0.proto_err, bus1.proto_err);
    end
    n_cmp++;
    if (st0 !== ST_IDLE || st1 !== ST_IDLE || bus1.cmd_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d/%0d oe1 %0b, required 0/0 oe1 0", st0, st1, bus1.cmd_oe);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_zero();
    int t0;
    clear_exp();
    issue_read(14'h0005, t0);
    push_read('0, t0, LAT0);
    wait_drain(LAT0 + NB + 10);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL read_zero_drain: %0d beats outstanding, required 0", exp_q.size());
      clear_exp();
    end
    @(negedge clk);
    n_cmp++;
    if (m_cmd_oe !== 1'b0 || m_data_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL read_zero_release: got cmd_oe %0b data_oe %0b, required 0 0", m_cmd_oe, m_data_oe);
    end
  endtask

  task automatic test_write_read();
    int t0;
    logic [LW-1:0] l;
    int r0;
    l = make_line(8'h00);
    clear_exp();
    r0 = n_resp;
    issue_write(14'h0123, l, NB, t0);
    model_line[key_of(1'b0, 14'h0123)] = l;
    push_write_resp(t0, LAT0);
    wait_drain(LAT0 + 10);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (n_resp - r0 !== 1 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL write_resp_len: got %0d response cycles, required 1", n_resp - r0);
      clear_exp();
    end
    issue_read(14'h0123, t0);
    push_read(model_get(key_of(1'b0, 14'h0123)), t0, LAT0);
    wait_drain(LAT0 + NB + 10);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL write_read_drain: %0d beats outstanding, required 0", exp_q.size());
      clear_exp();
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    logic [LW-1:0] l;
    l = make_line(8'h33);
    clear_exp();
    issue_write(14'h0125, l, NB, t0);
    model_line[key_of(1'b0, 14'h0125)] = l;
    push_write_resp(t0, LAT0);
    wait_drain(LAT0 + 10);
    // First idle cycle after the write response.
    issue_read(14'h0124, t0);
    push_read(model_get(key_of(1'b0, 14'h0124)), t0, LAT0);
    wait_drain(LAT0 + NB + 10);
    issue_read(14'h0123, t0);
    push_read(model_get(key_of(1'b0, 14'h0123)), t0, LAT0);
    wait_drain(LAT0 + NB + 10);
    issue_read(14'h0125, t0);
    push_read(model_get(key_of(1'b0, 14'h0125)), t0, LAT0);
    wait_drain(LAT0 + NB + 10);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL b2b_drain: %0d beats outstanding, required 0", exp_q.size());
      clear_exp();
    end
  endtask

  task automatic test_reset_abort();
    int t0;
    int r0;
    clear_exp();
    r0 = n_resp;
    issue_write(14'h0042, make_line(8'hA5), 3, t0);
    #1;
    n_cmp++;
    if (st0 !== ST_IDLE || bus0.cmd_oe !== 1'b0 || bus0.data_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got state %0d cmd_oe %0b data_oe %0b, required 0 0 0",
               st0, bus0.cmd_oe, bus0.data_oe);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (LAT0 + NB + 5) @(negedge clk);
    n_cmp++;
    if (n_resp - r0 !== 0) begin
      n_fail++;
      $display("FAIL abort_no_resp: got %0d response cycles, required 0", n_resp - r0);
    end
    issue_read(14'h0042, t0);
    push_read(model_get(key_of(1'b0, 14'h0042)), t0, LAT0);
    wait_drain(LAT0 + NB + 10);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL abort_read_drain: %0d beats outstanding, required 0", exp_q.size());
      clear_exp();
    end
  endtask

  task automatic test_protocol();
    int t0;
    logic exp_err;
`ifdef MEM_PROTOCOL_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    clear_exp();
    issue_read(14'h0123, t0);
    push_read(model_get(key_of(1'b0, 14'h0123)), t0, LAT0);
    repeat (10) @(negedge clk);
    cmd_drv  = C2_READ_LINE;
    addr_drv = 14'h0005;
    @(negedge clk);
    cmd_drv = C2_NOP;
    @(negedge clk);
    n_cmp++;
    if (bus0.proto_err !== exp_err) begin
      n_fail++;
      $display("FAIL proto_set: got %0b, required %0b", bus0.proto_err, exp_err);
    end
    wait_drain(LAT0 + NB + 10);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL proto_resp_drain: %0d beats outstanding, required 0", exp_q.size());
      clear_exp();
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus0.proto_err !== exp_err || st0 !== ST_IDLE) begin
      n_fail++;
      $display("FAIL proto_sticky: got err %0b state %0d, required err %0b state 0", bus0.proto_err, st0, exp_err);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus0.proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL proto_clear: got %0b, required 0", bus0.proto_err);
    end
    cmd_drv = C2_RESPONSE;
    @(negedge clk);
    cmd_drv = C2_NOP;
    @(negedge clk);
    n_cmp++;
    if (bus0.proto_err !== exp_err || st0 !== ST_IDLE || bus0.cmd_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL proto_idle_resp: got err %0b state %0d oe %0b, required err %0b state 0 oe 0",
               bus0.proto_err, st0, bus0.cmd_oe, exp_err);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_min_latency();
    int t0;
    logic [LW-1:0] l;
    l = make_line(8'h5A);
    sel = 1'b1;
    clear_exp();
    @(negedge clk);
    issue_write(14'h0033, l, NB, t0);
    model_line[key_of(1'b1, 14'h0033)] = l;
    push_write_resp(t0, LAT1);
    wait_drain(LAT1 + 10);
    issue_read(14'h0033, t0);
    push_read(model_get(key_of(1'b1, 14'h0033)), t0, LAT1);
    wait_drain(LAT1 + NB + 10);
    issue_read(14'h0123, t0);
    push_read(model_get(key_of(1'b1, 14'h0123)), t0, LAT1);
    wait_drain(LAT1 + NB + 10);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL minlat_drain: %0d beats outstanding, required 0", exp_q.size());
      clear_exp();
    end
    @(negedge clk);
    n_cmp++;
    if (bus1.cmd_oe !== 1'b0 || st1 !== ST_IDLE) begin
      n_fail++;
      $display("FAIL minlat_release: got oe %0b state %0d, required oe 0 state 0", bus1.cmd_oe, st1);
    end
    sel = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_read_zero();
    test_write_read();
    test_back_to_back();
    test_reset_abort();
    test_protocol();
    test_min_latency();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: simulation still running at time %0t, required to have finished", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
